// File: rtl/fifo_depth_stats_reader.sv
// Register-side reader for up to eight FIFO depth monitors.
// Single-outstanding read port with shadowed max and clear-on-read.
//
// Ports:
//   axi_aclk, axi_resetn       : clock, async active-low reset
//   mon_depth, mon_depth_max   : packed per-monitor depth / max values
//   mon_clear                  : one-cycle clear pulse per monitor
//   rd_req, rd_addr, rd_clr    : request, {idx[3:1], sel[0]}, clear qualifier
//   rd_ack, rd_data, rd_err    : registered response strobe, data, error
//   busy                       : request in flight
module fifo_depth_stats_reader #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_MON            = 4
) (
    input  logic                                  axi_aclk,
    input  logic                                  axi_resetn,
    input  logic [NUM_MON*C_S_AXI_DATA_WIDTH-1:0] mon_depth,
    input  logic [NUM_MON*C_S_AXI_DATA_WIDTH-1:0] mon_depth_max,
    output logic [NUM_MON-1:0]                    mon_clear,
    input  logic                                  rd_req,
    input  logic [3:0]                            rd_addr,
    input  logic                                  rd_clr,
    output logic                                  rd_ack,
    output logic [C_S_AXI_DATA_WIDTH-1:0]         rd_data,
    output logic                                  rd_err,
    output logic                                  busy
);

    localparam int W = C_S_AXI_DATA_WIDTH;
    localparam logic [W-1:0] ERR_DATA  = W'(32'hDEAD_0BAD);
    localparam logic [3:0]   NUM_MON_L = 4'(NUM_MON);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_RESP,
        S_CLR,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic                sel_q, sel_d;
    logic                clr_q, clr_d;
    logic                rd_ack_q, rd_ack_d;
    logic                rd_err_q, rd_err_d;
    logic [W-1:0]        rd_data_q, rd_data_d;
    logic [NUM_MON-1:0]  mon_clear_q, mon_clear_d;
    logic [7:0][W-1:0]   shadow_max_q, shadow_max_d;
    logic [7:0]          shadow_valid_q, shadow_valid_d;

    // Monitors padded to eight slots so a 3-bit index is always in range;
    // unpopulated slots are unreachable because they take the ERR path.
    logic [7:0][W-1:0]   depth_arr;
    logic [7:0][W-1:0]   max_arr;
    logic [7:0]          clr_onehot;

    always_comb begin
        depth_arr = '0;
        max_arr   = '0;
        for (int i = 0; i < NUM_MON; i++) begin
            depth_arr[i] = mon_depth[i*W +: W];
            max_arr[i]   = mon_depth_max[i*W +: W];
        end
    end

    assign clr_onehot = 8'b1 << idx_q;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        sel_d          = sel_q;
        clr_d          = clr_q;
        rd_ack_d       = 1'b0;
        rd_err_d       = 1'b0;
        rd_data_d      = rd_data_q;
        mon_clear_d    = '0;
        shadow_max_d   = shadow_max_q;
        shadow_valid_d = shadow_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    idx_d = rd_addr[3:1];
                    sel_d = rd_addr[0];
                    clr_d = rd_clr;
                    if ({1'b0, rd_addr[3:1]} >= NUM_MON_L) begin
                        // Error answers one cycle early, so the ack is
                        // registered on the way into ERR.
                        state_d   = S_ERR;
                        rd_ack_d  = 1'b1;
                        rd_err_d  = 1'b1;
                        rd_data_d = ERR_DATA;
                    end else begin
                        state_d = S_SNAP;
                    end
                end
            end
            S_SNAP: begin
                state_d  = S_RESP;
                rd_ack_d = 1'b1;
                if (!sel_q) begin
                    // Depth read freezes max so the next max read pairs
                    // with this depth sample.
                    rd_data_d             = depth_arr[idx_q];
                    shadow_max_d[idx_q]   = max_arr[idx_q];
                    shadow_valid_d[idx_q] = 1'b1;
                end else begin
                    rd_data_d = shadow_valid_q[idx_q] ?
                                shadow_max_q[idx_q] : max_arr[idx_q];
                    shadow_valid_d[idx_q] = 1'b0;
                end
            end
            S_RESP: begin
                if (clr_q) begin
                    state_d     = S_CLR;
                    mon_clear_d = clr_onehot[NUM_MON-1:0];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                shadow_valid_d[idx_q] = 1'b0;
                state_d               = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            sel_q          <= 1'b0;
            clr_q          <= 1'b0;
            rd_ack_q       <= 1'b0;
            rd_err_q       <= 1'b0;
            rd_data_q      <= '0;
            mon_clear_q    <= '0;
            shadow_max_q   <= '0;
            shadow_valid_q <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            sel_q          <= sel_d;
            clr_q          <= clr_d;
            rd_ack_q       <= rd_ack_d;
            rd_err_q       <= rd_err_d;
            rd_data_q      <= rd_data_d;
            mon_clear_q    <= mon_clear_d;
            shadow_max_q   <= shadow_max_d;
            shadow_valid_q <= shadow_valid_d;
        end
    end

    assign rd_ack    = rd_ack_q;
    assign rd_err    = rd_err_q;
    assign rd_data   = rd_data_q;
    assign mon_clear = mon_clear_q;
    assign busy      = (state_q != S_IDLE);

endmodule
